// File: rtl/adc_rx_align.sv
// Receive-side frame aligner: interleaves two 10-sample lanes, hunts for the
// training-frame rotation, confirms it, and emits time-ordered 20-sample frames.
module adc_rx_align #(
    parameter int             SW         = 14,
    parameter logic [SW-1:0]  MARKER     = 14'h2A5A,
    parameter int             LOCK_COUNT = 8,
    parameter int             MISS_LIMIT = 4
) (
    input  logic                      clk80,
    input  logic                      reset,
    input  logic [1:0][9:0][SW-1:0]   data_in,
    input  logic                      train_en,
    output logic [19:0][SW-1:0]       data_out,
    output logic                      data_valid,
    output logic                      aligned,
    output logic [4:0]                rotation,
    output logic                      align_err
);

    typedef enum logic [1:0] {IDLE, SEARCH, CONFIRM, LOCKED} state_t;

    state_t                state_q;
    logic [4:0]            r_q;
    logic [4:0]            r_d;
    logic [7:0]            hit_q;
    logic [7:0]            hit_d;
    logic [7:0]            miss_q;
    logic [7:0]            miss_d;
    logic [19:0][SW-1:0]   w_cur;
    logic [19:0][SW-1:0]   w_prev_q;
    logic [39:0][SW-1:0]   ext;
    logic [19:0][SW-1:0]   win;
    logic [19:0][SW-1:0]   data_out_q;
    logic                  valid_q;
    logic [4:0]            rot_q;
    logic                  err_q;
    logic                  match;

    always_comb begin
        w_cur = '0;
        for (int j = 0; j < 10; j++) begin
            w_cur[2*j]   = data_in[0][j];
            w_cur[2*j+1] = data_in[1][j];
        end
    end

    // Previous frame occupies the low half so ext[r] walks forward in time.
    assign ext = {w_cur, w_prev_q};

    always_comb begin
        win = '0;
        for (int i = 0; i < 20; i++) begin
            win[i] = ext[6'(r_q) + 6'(i)];
        end
    end

    always_comb begin
        match = (win[0] == MARKER);
        for (int i = 1; i < 20; i++) begin
            if (win[i] != SW'(i)) begin
                match = 1'b0;
            end
        end
    end

    assign r_d    = (r_q == 5'd19) ? 5'd0 : r_q + 5'd1;
    assign hit_d  = hit_q + 8'd1;
    assign miss_d = miss_q + 8'd1;

    always_ff @(posedge clk80) begin
        w_prev_q   <= w_cur;
        data_out_q <= win;
        err_q      <= 1'b0;
        if (reset) begin
            state_q    <= IDLE;
            r_q        <= 5'd0;
            hit_q      <= 8'd0;
            miss_q     <= 8'd0;
            w_prev_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            rot_q      <= 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    r_q     <= 5'd0;
                    rot_q   <= 5'd0;
                    hit_q   <= 8'd0;
                    miss_q  <= 8'd0;
                    valid_q <= 1'b0;
                    if (train_en) begin
                        state_q <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (!train_en) begin
                        state_q <= IDLE;
                        r_q     <= 5'd0;
                        rot_q   <= 5'd0;
                    end else if (match) begin
                        state_q <= CONFIRM;
                        hit_q   <= 8'd1;
                    end else begin
                        r_q   <= r_d;
                        rot_q <= r_d;
                    end
                end
                CONFIRM: begin
                    if (!train_en) begin
                        state_q <= IDLE;
                        r_q     <= 5'd0;
                        rot_q   <= 5'd0;
                        hit_q   <= 8'd0;
                    end else if (match) begin
                        if (hit_d >= 8'(LOCK_COUNT)) begin
                            state_q <= LOCKED;
                            miss_q  <= 8'd0;
                            valid_q <= 1'b1;
                        end
                        hit_q <= hit_d;
                    end else begin
                        state_q <= SEARCH;
                        hit_q   <= 8'd0;
                        r_q     <= r_d;
                        rot_q   <= r_d;
                    end
                end
                LOCKED: begin
                    if (!train_en || match) begin
                        miss_q <= 8'd0;
                    end else if (miss_d >= 8'(MISS_LIMIT)) begin
                        state_q <= SEARCH;
                        r_q     <= r_d;
                        rot_q   <= r_d;
                        hit_q   <= 8'd0;
                        miss_q  <= 8'd0;
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        miss_q <= miss_d;
                    end
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign aligned    = valid_q;
    assign rotation   = rot_q;
    assign align_err  = err_q;

endmodule
